// File: rtl/dc_motor_ctrl.sv
// H-bridge DC motor channel: ramps duty toward a commanded speed/direction once per PWM period,
// ramps to zero and waits a dead time before reversing. Optional braking via DC_MOTOR_CTRL_BRAKE_EN.
module dc_motor_ctrl #(
    parameter int CLK_FREQ        = 100000000,
    parameter int PWM_FREQ        = 20000,
    parameter int SPEED_WL        = $clog2(CLK_FREQ/PWM_FREQ+1),
    parameter int RAMP_STEP       = 16,
    parameter int DEADTIME_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cmd_vld,
    input  logic [SPEED_WL-1:0] cmd_speed,
    input  logic                cmd_dir,
    input  logic                estop,
`ifdef DC_MOTOR_CTRL_BRAKE_EN
    input  logic                brake,
`endif
    output logic                fwd_pwm,
    output logic                bwd_pwm,
    output logic [SPEED_WL-1:0] cur_speed,
    output logic                cur_dir,
    output logic                busy,
    output logic [1:0]          state
);

    localparam int PERIOD = CLK_FREQ / PWM_FREQ;
    localparam int DT_W   = $clog2(DEADTIME_CYCLES + 1);

    localparam logic [SPEED_WL-1:0] PERIOD_V  = SPEED_WL'(PERIOD);
    localparam logic [SPEED_WL-1:0] PERIOD_M1 = SPEED_WL'(PERIOD - 1);
    localparam logic [SPEED_WL:0]   PERIOD_X  = {1'b0, PERIOD_V};
    localparam logic [SPEED_WL:0]   STEP_X    = (SPEED_WL+1)'(RAMP_STEP);
    localparam logic [DT_W-1:0]     DT_LOAD   = DT_W'(DEADTIME_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2,
        DEADTIME = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [SPEED_WL-1:0] cnt_q, cnt_d;
    logic [SPEED_WL-1:0] tgt_speed_q, tgt_speed_d;
    logic                tgt_dir_q, tgt_dir_d;
    logic [SPEED_WL-1:0] cur_speed_q, cur_speed_d;
    logic                cur_dir_q, cur_dir_d;
    logic [DT_W-1:0]     dt_q, dt_d;
    logic                fwd_q, fwd_d;
    logic                bwd_q, bwd_d;

    logic                tick;
    logic                brake_in;
    logic [SPEED_WL-1:0] eff_speed;
    logic                eff_dir;
    logic [SPEED_WL:0]   goal_x;
    logic [SPEED_WL:0]   cur_x;
    logic [SPEED_WL:0]   ramp_x;
    logic [SPEED_WL-1:0] ramp_speed;
    logic                pwm_raw;
    logic                legs_on;

`ifdef DC_MOTOR_CTRL_BRAKE_EN
    assign brake_in = brake;
`else
    assign brake_in = 1'b0;
`endif

    assign tick = (cnt_q == PERIOD_M1);

    // Brake looks like a zero-speed command in the present direction, without disturbing the latched target.
    assign eff_speed = brake_in ? '0 : tgt_speed_q;
    assign eff_dir   = brake_in ? cur_dir_q : tgt_dir_q;

    // Bounded step toward the goal, computed one bit wider so the add cannot wrap.
    always_comb begin
        goal_x = '0;
        if (state_q == RUN) begin
            goal_x = {1'b0, eff_speed};
        end
        cur_x  = {1'b0, cur_speed_q};
        ramp_x = goal_x;
        if (goal_x > cur_x) begin
            if ((goal_x - cur_x) > STEP_X) begin
                ramp_x = cur_x + STEP_X;
            end
        end else if ((cur_x - goal_x) > STEP_X) begin
            ramp_x = cur_x - STEP_X;
        end
        if (ramp_x > PERIOD_X) begin
            ramp_x = PERIOD_X;
        end
        ramp_speed = ramp_x[SPEED_WL-1:0];
    end

    always_comb begin
        state_d     = state_q;
        cur_speed_d = cur_speed_q;
        cur_dir_d   = cur_dir_q;
        dt_d        = dt_q;
        tgt_speed_d = tgt_speed_q;
        tgt_dir_d   = tgt_dir_q;

        if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (cmd_vld) begin
            tgt_speed_d = (cmd_speed > PERIOD_V) ? PERIOD_V : cmd_speed;
            tgt_dir_d   = cmd_dir;
        end

        case (state_q)
            IDLE: begin
                cur_speed_d = '0;
                if (eff_speed != '0) begin
                    cur_dir_d = eff_dir;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    cur_speed_d = ramp_speed;
                end
                if (eff_dir != cur_dir_q) begin
                    state_d = STOPPING;
                end else if ((eff_speed == '0) && (cur_speed_q == '0)) begin
                    state_d = IDLE;
                end
            end
            STOPPING: begin
                if (tick) begin
                    cur_speed_d = ramp_speed;
                end
                if (eff_dir == cur_dir_q) begin
                    state_d = RUN;
                end else if (cur_speed_q == '0) begin
                    state_d = DEADTIME;
                    dt_d    = DT_LOAD;
                end
            end
            DEADTIME: begin
                if (dt_q == '0) begin
                    cur_dir_d = eff_dir;
                    state_d   = (eff_speed != '0) ? RUN : IDLE;
                end else begin
                    dt_d = dt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Emergency stop overrides everything and keeps the dead-time counter pinned at reload.
        if (estop) begin
            state_d     = DEADTIME;
            cur_speed_d = '0;
            dt_d        = DT_LOAD;
        end
    end

    always_comb begin
        pwm_raw = (cnt_q < cur_speed_q);
        legs_on = ((state_q == RUN) || (state_q == STOPPING)) && !estop;
        fwd_d   = pwm_raw && !cur_dir_q && legs_on;
        bwd_d   = pwm_raw &&  cur_dir_q && legs_on;
        if (brake_in && (state_q == IDLE) && !estop) begin
            fwd_d = 1'b1;
            bwd_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tgt_speed_q <= '0;
            tgt_dir_q   <= 1'b0;
            cur_speed_q <= '0;
            cur_dir_q   <= 1'b0;
            dt_q        <= '0;
            fwd_q       <= 1'b0;
            bwd_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tgt_speed_q <= tgt_speed_d;
            tgt_dir_q   <= tgt_dir_d;
            cur_speed_q <= cur_speed_d;
            cur_dir_q   <= cur_dir_d;
            dt_q        <= dt_d;
            fwd_q       <= fwd_d;
            bwd_q       <= bwd_d;
        end
    end

    assign fwd_pwm   = fwd_q;
    assign bwd_pwm   = bwd_q;
    assign cur_speed = cur_speed_q;
    assign cur_dir   = cur_dir_q;
    assign state     = state_q;
    assign busy      = (state_q == DEADTIME) || (cur_speed_q != eff_speed) || (cur_dir_q != eff_dir);

endmodule

// File: tb/tb_dc_motor_ctrl.sv
// Directed scoreboard bench for dc_motor_ctrl: PERIOD=100, dead time 50, ramp step 10 (main) and 30 (second instance).
module tb_dc_motor_ctrl;

    logic       clk;
    logic       resetn;
    logic       cmd_vld;
    logic [6:0] cmd_speed;
    logic       cmd_dir;
    logic       estop;
    logic       fwd_pwm;
    logic       bwd_pwm;
    logic [6:0] cur_speed;
    logic       cur_dir;
    logic       busy;
    logic [1:0] state;

    logic       cmd30_vld;
    logic [6:0] cmd30_speed;
    logic       cmd30_dir;
    logic       fwd30;
    logic       bwd30;
    logic [6:0] cur30_speed;
    logic       cur30_dir;
    logic       busy30;
    logic [1:0] state30;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   phase      = 0;
    int   both_high  = 0;
    int   fwd_seen   = 0;
    bit   watch_fwd  = 0;

    dc_motor_ctrl #(
        .CLK_FREQ(1000000), .PWM_FREQ(10000), .SPEED_WL(7),
        .RAMP_STEP(10), .DEADTIME_CYCLES(50)
    ) dut (
        .clk(clk), .resetn(resetn), .cmd_vld(cmd_vld), .cmd_speed(cmd_speed),
        .cmd_dir(cmd_dir), .estop(estop),
`ifdef DC_MOTOR_CTRL_BRAKE_EN
        .brake(1'b0),
`endif
        .fwd_pwm(fwd_pwm), .bwd_pwm(bwd_pwm), .cur_speed(cur_speed),
        .cur_dir(cur_dir), .busy(busy), .state(state)
    );

    dc_motor_ctrl #(
        .CLK_FREQ(1000000), .PWM_FREQ(10000), .SPEED_WL(7),
        .RAMP_STEP(30), .DEADTIME_CYCLES(50)
    ) dut30 (
        .clk(clk), .resetn(resetn), .cmd_vld(cmd30_vld), .cmd_speed(cmd30_speed),
        .cmd_dir(cmd30_dir), .estop(1'b0),
`ifdef DC_MOTOR_CTRL_BRAKE_EN
        .brake(1'b0),
`endif
        .fwd_pwm(fwd30), .bwd_pwm(bwd30), .cur_speed(cur30_speed),
        .cur_dir(cur30_dir), .busy(busy30), .state(state30)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference period counter: 0..99, cleared by reset, so phase 99 marks the tick edge.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) phase <= 0;
        else         phase <= (phase == 99) ? 0 : phase + 1;
    end

    always @(negedge clk) begin
        if (resetn && ((fwd_pwm && bwd_pwm) || (fwd30 && bwd30))) both_high <= both_high + 1;
        if (watch_fwd && fwd_pwm) fwd_seen <= fwd_seen + 1;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    task automatic pushExpected(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb_q.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] observed);
        exp_t e;
        compared++;
        assert (sb_q.size() != 0) else begin
            mismatched++;
            $error("[TB] FAIL scoreboard_empty: observed %0d expected a queued entry", observed);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            assert (observed === e.value) else begin
                mismatched++;
                $error("[TB] FAIL %s: observed %0d expected %0d", e.tag, observed, e.value);
            end
        end
    endtask

    task automatic applyStimulus(input bit sel30, input int speed, input bit dir);
        if (sel30) begin
            cmd30_speed = 7'(speed);
            cmd30_dir   = dir;
            cmd30_vld   = 1'b1;
        end else begin
            cmd_speed = 7'(speed);
            cmd_dir   = dir;
            cmd_vld   = 1'b1;
        end
        @(negedge clk);
        cmd_vld   = 1'b0;
        cmd30_vld = 1'b0;
    endtask

    task automatic nextTick();
        do @(negedge clk); while (phase != 0);
    endtask

    task automatic waitPhase(input int p);
        do @(negedge clk); while (phase != p);
    endtask

    task automatic countLegs(input int cycles, output int fwd_n, output int bwd_n);
        fwd_n = 0;
        bwd_n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (fwd_pwm) fwd_n++;
            if (bwd_pwm) bwd_n++;
            @(negedge clk);
        end
    endtask

    task automatic rampCheck(input string tag, input int first, input int step, input int n);
        for (int i = 0; i < n; i++) pushExpected(tag, 32'(first + i * step));
        for (int i = 0; i < n; i++) begin
            nextTick();
            checkOutput(32'(cur_speed));
        end
    endtask

    initial begin
        int fwd_n;
        int bwd_n;
        int n;
        int legs_hi;
        int hold_err;

        resetn = 1'b0; cmd_vld = 1'b0; cmd_speed = '0; cmd_dir = 1'b0; estop = 1'b0;
        cmd30_vld = 1'b0; cmd30_speed = '0; cmd30_dir = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        pushExpected("rst_fwd", 0);   checkOutput(32'(fwd_pwm));
        pushExpected("rst_bwd", 0);   checkOutput(32'(bwd_pwm));
        pushExpected("rst_speed", 0); checkOutput(32'(cur_speed));
        pushExpected("rst_dir", 0);   checkOutput(32'(cur_dir));
        pushExpected("rst_busy", 0);  checkOutput(32'(busy));
        pushExpected("rst_state", 0); checkOutput(32'(state));
        resetn = 1'b1;
        repeat (150) @(negedge clk);
        pushExpected("idle_no_cmd_state", 0); checkOutput(32'(state));

        $display("[TB] step 30 instance, no overshoot, command coincident with tick");
        nextTick();
        applyStimulus(1'b1, 50, 1'b0);
        pushExpected("s30_ramp", 30);
        pushExpected("s30_ramp", 50);
        nextTick(); checkOutput(32'(cur30_speed));
        nextTick(); checkOutput(32'(cur30_speed));
        waitPhase(99);
        pushExpected("s30_tick_hold", 50);
        pushExpected("s30_next_tick", 80);
        applyStimulus(1'b1, 80, 1'b0);
        checkOutput(32'(cur30_speed));
        nextTick(); checkOutput(32'(cur30_speed));
        pushExpected("s30_busy", 0);  checkOutput(32'(busy30));
        pushExpected("s30_state", 1); checkOutput(32'(state30));
        pushExpected("s30_dir", 0);   checkOutput(32'(cur30_dir));

        $display("[TB] forward ramp to 50");
        nextTick();
        applyStimulus(1'b0, 50, 1'b0);
        @(negedge clk);
        pushExpected("run_state", 1);  checkOutput(32'(state));
        pushExpected("run_busy", 1);   checkOutput(32'(busy));
        rampCheck("fwd_ramp", 10, 10, 5);
        pushExpected("busy_at_50", 0); checkOutput(32'(busy));
        countLegs(100, fwd_n, bwd_n);
        pushExpected("fwd_duty50", 50); checkOutput(32'(fwd_n));
        pushExpected("bwd_idle", 0);    checkOutput(32'(bwd_n));

        $display("[TB] saturating command");
        applyStimulus(1'b0, 120, 1'b0);
        rampCheck("sat_ramp", 60, 10, 5);
        @(negedge clk);
        countLegs(100, fwd_n, bwd_n);
        pushExpected("fwd_duty100", 100); checkOutput(32'(fwd_n));
        pushExpected("sat_hold", 100);    checkOutput(32'(cur_speed));

        $display("[TB] reversal with dead time");
        applyStimulus(1'b0, 50, 1'b0);
        rampCheck("down_to_50", 90, -10, 5);
        applyStimulus(1'b0, 30, 1'b1);
        @(negedge clk);
        pushExpected("stop_state", 2); checkOutput(32'(state));
        rampCheck("stop_ramp", 40, -10, 5);
        pushExpected("stop_at_zero_state", 2); checkOutput(32'(state));
        @(negedge clk);
        watch_fwd = 1'b1;
        n = 0;
        legs_hi = 0;
        while (state == 2'd3 && n < 200) begin
            n++;
            if (fwd_pwm || bwd_pwm) legs_hi++;
            @(negedge clk);
        end
        pushExpected("deadtime_len", 50);    checkOutput(32'(n));
        pushExpected("deadtime_legs", 0);    checkOutput(32'(legs_hi));
        pushExpected("after_dt_state", 1);   checkOutput(32'(state));
        pushExpected("after_dt_dir", 1);     checkOutput(32'(cur_dir));
        rampCheck("bwd_ramp", 10, 10, 3);
        @(negedge clk);
        countLegs(100, fwd_n, bwd_n);
        pushExpected("bwd_duty30", 30); checkOutput(32'(bwd_n));

        $display("[TB] emergency stop");
        applyStimulus(1'b0, 50, 1'b1);
        rampCheck("bwd_to_50", 40, 10, 2);
        estop = 1'b1;
        @(negedge clk);
        pushExpected("estop_fwd", 0);   checkOutput(32'(fwd_pwm));
        pushExpected("estop_bwd", 0);   checkOutput(32'(bwd_pwm));
        pushExpected("estop_speed", 0); checkOutput(32'(cur_speed));
        pushExpected("estop_state", 3); checkOutput(32'(state));
        hold_err = 0;
        repeat (60) begin
            if (state != 2'd3) hold_err++;
            @(negedge clk);
        end
        applyStimulus(1'b0, 20, 1'b1);
        repeat (138) begin
            if (state != 2'd3) hold_err++;
            @(negedge clk);
        end
        pushExpected("estop_hold", 0); checkOutput(32'(hold_err));
        estop = 1'b0;
        n = 0;
        while (state == 2'd3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        pushExpected("estop_release_len", 50); checkOutput(32'(n));
        pushExpected("estop_resume_state", 1); checkOutput(32'(state));
        rampCheck("estop_ramp", 10, 10, 2);
        pushExpected("estop_busy", 0); checkOutput(32'(busy));
        watch_fwd = 1'b0;
        pushExpected("fwd_after_reversal", 0); checkOutput(32'(fwd_seen));

        $display("[TB] reset mid run");
        applyStimulus(1'b0, 40, 1'b1);
        rampCheck("pre_reset_ramp", 30, 10, 2);
        repeat (10) @(negedge clk);
        pushExpected("pre_reset_bwd", 1); checkOutput(32'(bwd_pwm));
        resetn = 1'b0;
        #1;
        pushExpected("async_rst_fwd", 0);   checkOutput(32'(fwd_pwm));
        pushExpected("async_rst_bwd", 0);   checkOutput(32'(bwd_pwm));
        pushExpected("async_rst_speed", 0); checkOutput(32'(cur_speed));
        pushExpected("async_rst_state", 0); checkOutput(32'(state));
        pushExpected("async_rst_busy", 0);  checkOutput(32'(busy));
        @(negedge clk);
        resetn = 1'b1;
        legs_hi = 0;
        repeat (250) begin
            if (fwd_pwm || bwd_pwm) legs_hi++;
            @(negedge clk);
        end
        pushExpected("post_rst_legs", 0);  checkOutput(32'(legs_hi));
        pushExpected("post_rst_state", 0); checkOutput(32'(state));
        pushExpected("post_rst_speed", 0); checkOutput(32'(cur_speed));

        pushExpected("legs_never_both", 0); checkOutput(32'(both_high));
        compared++;
        assert (sb_q.size() == 0) else begin
            mismatched++;
            $error("[TB] FAIL scoreboard_leftover: observed %0d expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
